// File: rtl/fwd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_pkg
//  Purpose  : Shared forwarding-select encodings and pipeline-slot tag types
//             for the forwarding / load-use hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package fwd_pkg;

    localparam int unsigned TAG_W = 5;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_WB  = 2'b01;
    localparam fwd_sel_t FWD_MEM = 2'b10;

    localparam logic [TAG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic             v;
        logic [TAG_W-1:0] rs;
        logic [TAG_W-1:0] rt;
        logic             uses_rt;
        logic [TAG_W-1:0] rd;
        logic             rw;
        logic             mr;
    } ex_slot_t;

endpackage : fwd_pkg
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl_if
//  Purpose  : ID-stage tag bus into the hazard controller and its stall /
//             forwarding-select outputs. FWD_PERF_CNT_EN adds counter outputs.
//  Revision : 1.0 - initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
`ifdef FWD_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;
`else
    // CNT_W only sizes the counters; referenced here so both builds elaborate cleanly.
    if (CNT_W == 0) begin : g_no_perf_cnt
    end
`endif

    modport master (
        output id_valid, output id_rs, output id_rt, output id_uses_rt,
        output id_rd, output id_regwrite, output id_memread, output flush,
        input  stall, input fwd_sel_a, input fwd_sel_b
`ifdef FWD_PERF_CNT_EN
        , input stall_cnt, input fwd_cnt
`endif
    );

    modport slave (
        input  id_valid, input id_rs, input id_rt, input id_uses_rt,
        input  id_rd, input id_regwrite, input id_memread, input flush,
        output stall, output fwd_sel_a, output fwd_sel_b
`ifdef FWD_PERF_CNT_EN
        , output stall_cnt, output fwd_cnt
`endif
    );

endinterface : fwd_hazard_ctrl_if
`default_nettype wire

// File: rtl/fwd_sel_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_sel_cmp
//  Purpose  : Combinational operand-select for one EX operand: compares the
//             source tag against the MEM and WB slots, MEM (newer) first.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_sel_cmp
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  wire logic              i_src_en,
    input  wire logic [REG_AW-1:0] i_src,
    input  wire logic              i_mem_v,
    input  wire logic              i_mem_rw,
    input  wire logic [REG_AW-1:0] i_mem_rd,
    input  wire logic              i_wb_v,
    input  wire logic              i_wb_rw,
    input  wire logic [REG_AW-1:0] i_wb_rd,
    output fwd_sel_t               o_sel
);

    logic w_mem_hit;
    logic w_wb_hit;

    always_comb begin
        // Register 0 reads as zero, so a write to it must never be forwarded.
        w_mem_hit = i_mem_v & i_mem_rw & (i_mem_rd != '0) & (i_mem_rd == i_src);
        w_wb_hit  = i_wb_v  & i_wb_rw  & (i_wb_rd  != '0) & (i_wb_rd  == i_src);
        o_sel     = FWD_RF;
        if (i_src_en) begin
            if (w_mem_hit) begin
                o_sel = FWD_MEM;
            end else if (w_wb_hit) begin
                o_sel = FWD_WB;
            end
        end
    end

endmodule : fwd_sel_cmp
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fwd_hazard_ctrl
//  Purpose  : Tag shadow pipeline (EX/MEM/WB), load-use stall with bubble
//             injection, and EX operand forwarding selects.
//             Optional: `define FWD_PERF_CNT_EN adds saturating counters.
//  Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fwd_hazard_ctrl_if.slave    bus
);

    ex_slot_t          ex_d, ex_q;
    logic              mem_v_d, mem_v_q;
    logic [TAG_W-1:0]  mem_rd_d, mem_rd_q;
    logic              mem_rw_d, mem_rw_q;
    logic              mem_mr_d, mem_mr_q;
    logic              wb_v_d, wb_v_q;
    logic [TAG_W-1:0]  wb_rd_d, wb_rd_q;
    logic              wb_rw_d, wb_rw_q;

    logic              w_stall;
    fwd_sel_t          w_sel_a;
    fwd_sel_t          w_sel_b;
    logic              w_mem_load_hit;

    always_comb begin
        w_stall = bus.id_valid & ~bus.flush & ex_q.v & ex_q.mr & (ex_q.rd != REG_ZERO) &
                  ((ex_q.rd == bus.id_rs) | (bus.id_uses_rt & (ex_q.rd == bus.id_rt)));

        // Flushed or stalled ID enters EX as a bubble; flush outranks stall.
        ex_d = '0;
        if (!bus.flush && !w_stall) begin
            ex_d.v       = bus.id_valid;
            ex_d.rs      = bus.id_rs;
            ex_d.rt      = bus.id_rt;
            ex_d.uses_rt = bus.id_uses_rt;
            ex_d.rd      = bus.id_rd;
            ex_d.rw      = bus.id_regwrite;
            ex_d.mr      = bus.id_memread;
        end

        mem_v_d  = ex_q.v;
        mem_rd_d = ex_q.rd;
        mem_rw_d = ex_q.rw;
        mem_mr_d = ex_q.mr;
        wb_v_d   = mem_v_q;
        wb_rd_d  = mem_rd_q;
        wb_rw_d  = mem_rw_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= '0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_rw_q <= 1'b0;
            mem_mr_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= '0;
            wb_rw_q  <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_v_q  <= mem_v_d;
            mem_rd_q <= mem_rd_d;
            mem_rw_q <= mem_rw_d;
            mem_mr_q <= mem_mr_d;
            wb_v_q   <= wb_v_d;
            wb_rd_q  <= wb_rd_d;
            wb_rw_q  <= wb_rw_d;
        end
    end

    fwd_sel_cmp #(.REG_AW(TAG_W)) u_sel_a (
        .i_src_en (ex_q.v),
        .i_src    (ex_q.rs),
        .i_mem_v  (mem_v_q),
        .i_mem_rw (mem_rw_q),
        .i_mem_rd (mem_rd_q),
        .i_wb_v   (wb_v_q),
        .i_wb_rw  (wb_rw_q),
        .i_wb_rd  (wb_rd_q),
        .o_sel    (w_sel_a)
    );

    fwd_sel_cmp #(.REG_AW(TAG_W)) u_sel_b (
        .i_src_en (ex_q.v & ex_q.uses_rt),
        .i_src    (ex_q.rt),
        .i_mem_v  (mem_v_q),
        .i_mem_rw (mem_rw_q),
        .i_mem_rd (mem_rd_q),
        .i_wb_v   (wb_v_q),
        .i_wb_rw  (wb_rw_q),
        .i_wb_rd  (wb_rd_q),
        .o_sel    (w_sel_b)
    );

    assign bus.stall     = w_stall;
    assign bus.fwd_sel_a = w_sel_a;
    assign bus.fwd_sel_b = w_sel_b;

    // A load in MEM feeding the instruction in EX means the load-use stall was missed.
    assign w_mem_load_hit = ex_q.v & mem_v_q & mem_mr_q & (mem_rd_q != REG_ZERO) &
                            ((mem_rd_q == ex_q.rs) | (ex_q.uses_rt & (mem_rd_q == ex_q.rt)));

    a_no_mem_load_fwd : assert property (@(posedge clk) disable iff (rst) !w_mem_load_hit);

`ifdef FWD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_d, fwd_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (((w_sel_a != FWD_RF) || (w_sel_b != FWD_RF)) && (fwd_cnt_q != {CNT_W{1'b1}})) begin
            fwd_cnt_d = fwd_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`else
    if (CNT_W == 0) begin : g_no_perf_cnt
    end
`endif

endmodule : fwd_hazard_ctrl
`default_nettype wire
